// File: rtl/minimig_acfg_pkg.sv
// Shared constants for the autoconfig chain: config-window register offsets,
// board type nibbles and the sequencer state encoding.
package minimig_acfg_pkg;

  localparam logic [8:0] ER_TYPE    = 9'h000;
  localparam logic [8:0] ER_SIZE    = 9'h002;
  localparam logic [8:0] ER_PROD_HI = 9'h004;
  localparam logic [8:0] ER_PROD_LO = 9'h006;
  localparam logic [8:0] ER_FLAGS   = 9'h008;
  localparam logic [8:0] ER_MANUF_0 = 9'h010;
  localparam logic [8:0] ER_MANUF_1 = 9'h012;
  localparam logic [8:0] ER_MANUF_2 = 9'h014;
  localparam logic [8:0] ER_MANUF_3 = 9'h016;
  localparam logic [8:0] EC_BASE_Z3 = 9'h044;
  localparam logic [8:0] EC_BASE_Z2 = 9'h048;
  localparam logic [8:0] EC_BASE_LO = 9'h04A;
  localparam logic [8:0] EC_SHUTUP  = 9'h04C;

  localparam logic [3:0] TYPE_Z2 = 4'hE;
  localparam logic [3:0] TYPE_Z3 = 4'hA;

  typedef enum logic [1:0] {S_INIT, S_CFG, S_DONE} acfg_state_e;

endpackage

// File: rtl/minimig_acfg_next_board.sv
// Priority encoder: lowest eligible slot index >= start_i, or NUM_BOARDS when
// no such slot exists (the "chain done" code).
module minimig_acfg_next_board
  import minimig_acfg_pkg::*;
#(
  parameter int NUM_BOARDS = 5,
  parameter int IDXW       = $clog2(NUM_BOARDS + 1)
) (
  input  logic [NUM_BOARDS-1:0] eligible_i,
  input  logic [IDXW-1:0]       start_i,
  output logic [IDXW-1:0]       next_o
);

  always_comb begin
    next_o = IDXW'(NUM_BOARDS);
    for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
      if (eligible_i[i] && (i >= int'(start_i))) next_o = IDXW'(i);
    end
  end

endmodule

// File: rtl/minimig_autoconfig_chain.sv
// Zorro II/III autoconfig sequencer presenting NUM_BOARDS descriptor-driven boards
// one at a time. Optional Z2 A19..16 low-nibble base write: AUTOCONFIG_Z2_LOWNIB_EN.
module minimig_autoconfig_chain
  import minimig_acfg_pkg::*;
#(
  parameter int          NUM_BOARDS = 5,
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter int          IDXW       = $clog2(NUM_BOARDS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk7_en,
  input  logic [7:0]              address_in,
  input  logic [15:0]             data_in,
  output logic [15:0]             data_out,
  input  logic                    rd,
  input  logic                    hwr,
  input  logic                    lwr,
  input  logic                    sel,
  input  logic                    m68020,
  input  logic [NUM_BOARDS-1:0]   board_enable,
  input  logic [NUM_BOARDS-1:0]   board_z3,
  input  logic [3*NUM_BOARDS-1:0] board_size,
  input  logic [8*NUM_BOARDS-1:0] board_prod,
  output logic [NUM_BOARDS-1:0]   board_configured,
  output logic [NUM_BOARDS-1:0]   board_shutup,
  output logic [16*NUM_BOARDS-1:0] board_base,
  output logic [IDXW-1:0]         cur_board,
  output logic                    autoconfig_done
);

  localparam logic [IDXW-1:0] DONE_IDX = IDXW'(NUM_BOARDS);

  acfg_state_e              state_q, state_d;
  logic [IDXW-1:0]          curBoard_q, curBoard_d;
  logic [NUM_BOARDS-1:0]    eligible_q, eligible_d;
  logic [NUM_BOARDS-1:0]    configured_q, configured_d;
  logic [NUM_BOARDS-1:0]    shutup_q, shutup_d;
  logic [16*NUM_BOARDS-1:0] base_q, base_d;
  logic                     armed_q, armed_d;
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
  logic [3:0]               pending_q, pending_d;
`endif

  logic [NUM_BOARDS-1:0] eligibleNow, encEligible;
  logic [IDXW-1:0]       encStart, nextIdx;
  logic [8:0]            offset;
  logic                  selZ3, chained, writeReq, fire, advance;
  logic [2:0]            selSize;
  logic [7:0]            selProd, wrByte;
  logic [3:0]            nib;
  logic                  unusedRd;

  assign unusedRd    = rd;
  assign offset      = {address_in, 1'b0};
  assign wrByte      = hwr ? data_in[15:8] : data_in[7:0];
  assign eligibleNow = board_enable & (~board_z3 | {NUM_BOARDS{m68020}});

  // One encoder serves both the initial search from slot 0 and every advance.
  assign encEligible = (state_q == S_INIT) ? eligibleNow : eligible_q;
  assign encStart    = (state_q == S_INIT) ? '0 : curBoard_q + IDXW'(1);
  assign chained     = (nextIdx != DONE_IDX);

  minimig_acfg_next_board #(
    .NUM_BOARDS(NUM_BOARDS),
    .IDXW      (IDXW)
  ) u_next (
    .eligible_i(encEligible),
    .start_i   (encStart),
    .next_o    (nextIdx)
  );

  always_comb begin
    selZ3   = 1'b0;
    selSize = '0;
    selProd = '0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (curBoard_q == IDXW'(i)) begin
        selZ3   = board_z3[i];
        selSize = board_size[3*i +: 3];
        selProd = board_prod[8*i +: 8];
      end
    end
  end

  always_comb begin
    nib = 4'hF;
    if (state_q == S_CFG) begin
      case (offset)
        ER_TYPE:    nib = selZ3 ? TYPE_Z3 : TYPE_Z2;
        ER_SIZE:    nib = {chained, selSize};
        ER_PROD_HI: nib = ~selProd[7:4];
        ER_PROD_LO: nib = ~selProd[3:0];
        ER_FLAGS:   nib = ~{selZ3, 3'b000};
        ER_MANUF_0: nib = ~MANUF_ID[15:12];
        ER_MANUF_1: nib = ~MANUF_ID[11:8];
        ER_MANUF_2: nib = ~MANUF_ID[7:4];
        ER_MANUF_3: nib = ~MANUF_ID[3:0];
        default:    nib = 4'hF;
      endcase
    end
  end

  assign data_out = sel ? {nib, 12'hFFF} : 16'h0000;

  // A write held across several bus cycles acts once; rearm when it goes away.
  assign writeReq = sel & (hwr | lwr);
  assign fire     = clk7_en & writeReq & armed_q;
  assign armed_d  = fire ? 1'b0 : (!writeReq ? 1'b1 : armed_q);

  always_comb begin
    state_d      = state_q;
    curBoard_d   = curBoard_q;
    eligible_d   = eligible_q;
    configured_d = configured_q;
    shutup_d     = shutup_q;
    base_d       = base_q;
    advance      = 1'b0;
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
    pending_d    = pending_q;
`endif
    case (state_q)
      S_INIT: begin
        eligible_d = eligibleNow;
        curBoard_d = nextIdx;
        state_d    = (nextIdx == DONE_IDX) ? S_DONE : S_CFG;
      end
      S_CFG: begin
        if (fire) begin
          for (int i = 0; i < NUM_BOARDS; i++) begin
            if (curBoard_q == IDXW'(i)) begin
              if (offset == EC_BASE_Z2 && !selZ3) begin
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
                base_d[16*i +: 8] = {wrByte[7:4], pending_q};
`else
                base_d[16*i +: 8] = wrByte;
`endif
                configured_d[i] = 1'b1;
                advance         = 1'b1;
              end else if (offset == EC_BASE_Z3 && selZ3) begin
                base_d[16*i +: 16] = data_in;
                configured_d[i]    = 1'b1;
                advance            = 1'b1;
              end else if (offset == EC_SHUTUP) begin
                shutup_d[i] = 1'b1;
                advance     = 1'b1;
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
              end else if (offset == EC_BASE_LO && !selZ3) begin
                pending_d = wrByte[7:4];
`endif
              end
            end
          end
          if (advance) begin
            curBoard_d = nextIdx;
            if (nextIdx == DONE_IDX) state_d = S_DONE;
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
            pending_d = 4'h0;
`endif
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      curBoard_q   <= '0;
      eligible_q   <= '0;
      configured_q <= '0;
      shutup_q     <= '0;
      base_q       <= '0;
      armed_q      <= 1'b1;
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
      pending_q    <= 4'h0;
`endif
    end else begin
      state_q      <= state_d;
      curBoard_q   <= curBoard_d;
      eligible_q   <= eligible_d;
      configured_q <= configured_d;
      shutup_q     <= shutup_d;
      base_q       <= base_d;
      armed_q      <= armed_d;
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
      pending_q    <= pending_d;
`endif
    end
  end

  assign board_configured = configured_q;
  assign board_shutup     = shutup_q;
  assign board_base       = base_q;
  assign cur_board        = curBoard_q;
  assign autoconfig_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// Scoreboard bench for minimig_autoconfig_chain (NUM_BOARDS=5): expectations are
// queued as stimulus is applied and compared once the DUT has settled.
module tb_minimig_autoconfig_chain;

  localparam int K_DATA = 0;
  localparam int K_CUR  = 1;
  localparam int K_BASE = 2;
  localparam int K_CONF = 3;
  localparam int K_SHUT = 4;
  localparam int K_DONE = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic [7:0]  address_in;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd, hwr, lwr, sel, m68020;
  logic [4:0]  board_enable, board_z3;
  logic [14:0] board_size;
  logic [39:0] board_prod;
  logic [4:0]  board_configured, board_shutup;
  logic [79:0] board_base;
  logic [2:0]  cur_board;
  logic        autoconfig_done;

  typedef struct {
    string       tag;
    int          kind;
    int          slot;
    logic [15:0] val;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  minimig_autoconfig_chain dut (
    .clk             (clk),
    .reset           (reset),
    .clk7_en         (clk7_en),
    .address_in      (address_in),
    .data_in         (data_in),
    .data_out        (data_out),
    .rd              (rd),
    .hwr             (hwr),
    .lwr             (lwr),
    .sel             (sel),
    .m68020          (m68020),
    .board_enable    (board_enable),
    .board_z3        (board_z3),
    .board_size      (board_size),
    .board_prod      (board_prod),
    .board_configured(board_configured),
    .board_shutup    (board_shutup),
    .board_base      (board_base),
    .cur_board       (cur_board),
    .autoconfig_done (autoconfig_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int kind, input int slot);
    case (kind)
      K_DATA:  return data_out;
      K_CUR:   return {13'h0, cur_board};
      K_BASE:  return board_base[16*slot +: 16];
      K_CONF:  return {11'h0, board_configured};
      K_SHUT:  return {11'h0, board_shutup};
      K_DONE:  return {15'h0, autoconfig_done};
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic expectVal(input string tag, input int kind, input int slot, input logic [15:0] val);
    expT e;
    e.tag  = tag;
    e.kind = kind;
    e.slot = slot;
    e.val  = val;
    sbQ.push_back(e);
  endtask

  task automatic compareScoreboard();
    expT e;
    #1;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput(e.tag, observe(e.kind, e.slot), e.val);
    end
  endtask

  task automatic goIdle();
    sel = 1'b0; rd = 1'b0; hwr = 1'b0; lwr = 1'b0;
    address_in = 8'h00; data_in = 16'h0000;
  endtask

  // Drive a write for the given number of clocks, then drop the bus at a negedge.
  task automatic applyStimulus(input logic [8:0] offset, input logic [15:0] data,
                               input logic hi, input int cycles);
    @(negedge clk);
    address_in = offset[8:1];
    data_in    = data;
    sel        = 1'b1;
    hwr        = hi;
    lwr        = ~hi;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    goIdle();
  endtask

  task automatic readCheck(input string tag, input logic [8:0] offset, input logic [15:0] exp);
    address_in = offset[8:1];
    sel        = 1'b1;
    rd         = 1'b1;
    expectVal(tag, K_DATA, 0, exp);
    compareScoreboard();
    goIdle();
  endtask

  task automatic doReset();
    goIdle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clk7_en      = 1'b1;
    m68020       = 1'b0;
    board_enable = 5'b11111;
    board_z3     = 5'b00110;
    board_size   = {3'b001, 3'b000, 3'b000, 3'b000, 3'b010};
    board_prod   = {8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
    goIdle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    expectVal("rst_cur", K_CUR, 0, 16'h0);
    expectVal("rst_done", K_DONE, 0, 16'h0);
    expectVal("rst_conf", K_CONF, 0, 16'h0);
    expectVal("rst_base0", K_BASE, 0, 16'h0);
    expectVal("rst_dout", K_DATA, 0, 16'h0);
    compareScoreboard();
    reset = 1'b0;
    @(negedge clk);

    // Chain 1: 68000, slots 1/2 Z3 and therefore skipped.
    expectVal("s1_cur0", K_CUR, 0, 16'd0);
    compareScoreboard();
    readCheck("s1_type", 9'h000, 16'hEFFF);
    readCheck("s1_size", 9'h002, 16'hAFFF);
    readCheck("s1_flags", 9'h008, 16'hFFFF);
    readCheck("s1_man0", 9'h010, 16'hFFFF);
    readCheck("s1_man1", 9'h012, 16'h8FFF);
    readCheck("s1_man2", 9'h014, 16'h2FFF);
    readCheck("s1_man3", 9'h016, 16'h4FFF);
    readCheck("s1_other", 9'h020, 16'hFFFF);
    applyStimulus(9'h044, 16'h1234, 1'b1, 1);
    expectVal("s1_z3wr_on_z2", K_CUR, 0, 16'd0);
    compareScoreboard();
    clk7_en = 1'b0;
    applyStimulus(9'h048, 16'h2000, 1'b1, 1);
    clk7_en = 1'b1;
    expectVal("s1_noen_cur", K_CUR, 0, 16'd0);
    expectVal("s1_noen_conf", K_CONF, 0, 16'h0);
    compareScoreboard();
    applyStimulus(9'h048, 16'h2000, 1'b1, 1);
    expectVal("s1_base0", K_BASE, 0, 16'h0020);
    expectVal("s1_conf", K_CONF, 0, 16'h0001);
    expectVal("s1_cur3", K_CUR, 0, 16'd3);
    compareScoreboard();
    applyStimulus(9'h048, 16'h0033, 1'b0, 1);
    expectVal("s1_base3_lwr", K_BASE, 3, 16'h0033);
    expectVal("s1_cur4", K_CUR, 0, 16'd4);
    compareScoreboard();
    readCheck("s1_last_size", 9'h002, 16'h1FFF);
    applyStimulus(9'h04C, 16'h0000, 1'b1, 1);
    expectVal("s1_shut", K_SHUT, 0, 16'h0010);
    expectVal("s1_cur_done", K_CUR, 0, 16'd5);
    expectVal("s1_done", K_DONE, 0, 16'h1);
    compareScoreboard();
    readCheck("s1_done_read", 9'h000, 16'hFFFF);
    applyStimulus(9'h048, 16'hAB00, 1'b1, 1);
    expectVal("s1_done_base4", K_BASE, 4, 16'h0000);
    expectVal("s1_done_conf", K_CONF, 0, 16'h0009);
    compareScoreboard();

    // Chain 2: 68020, Z3 slots become eligible.
    m68020 = 1'b1;
    doReset();
    applyStimulus(9'h04C, 16'h0000, 1'b1, 1);
    expectVal("s2_shut0", K_SHUT, 0, 16'h0001);
    expectVal("s2_conf0", K_CONF, 0, 16'h0000);
    expectVal("s2_base0", K_BASE, 0, 16'h0000);
    expectVal("s2_cur1", K_CUR, 0, 16'd1);
    compareScoreboard();
    readCheck("s2_type_z3", 9'h000, 16'hAFFF);
    readCheck("s2_prod_hi", 9'h004, 16'hEFFF);
    readCheck("s2_prod_lo", 9'h006, 16'hFFFF);
    readCheck("s2_flags_z3", 9'h008, 16'h7FFF);
    applyStimulus(9'h048, 16'h9900, 1'b1, 1);
    expectVal("s2_z2wr_on_z3", K_CUR, 0, 16'd1);
    compareScoreboard();
    applyStimulus(9'h044, 16'h4000, 1'b1, 1);
    expectVal("s2_base1", K_BASE, 1, 16'h4000);
    expectVal("s2_conf1", K_CONF, 0, 16'h0002);
    expectVal("s2_cur2", K_CUR, 0, 16'd2);
    compareScoreboard();
    applyStimulus(9'h044, 16'h5000, 1'b1, 4);
    expectVal("s2_hold_cur", K_CUR, 0, 16'd3);
    expectVal("s2_hold_base2", K_BASE, 2, 16'h5000);
    expectVal("s2_hold_base3", K_BASE, 3, 16'h0000);
    compareScoreboard();
    applyStimulus(9'h048, 16'h7700, 1'b1, 1);
    expectVal("s2_base3", K_BASE, 3, 16'h0077);
    expectVal("s2_conf", K_CONF, 0, 16'h000E);
    expectVal("s2_cur4", K_CUR, 0, 16'd4);
    compareScoreboard();

    // Chain 3: asynchronous reset in the middle of the chain.
    doReset();
    applyStimulus(9'h04C, 16'h0000, 1'b1, 1);
    applyStimulus(9'h04C, 16'h0000, 1'b1, 1);
    expectVal("s3_cur2", K_CUR, 0, 16'd2);
    compareScoreboard();
    #1 reset = 1'b1;
    expectVal("s3_arst_cur", K_CUR, 0, 16'd0);
    expectVal("s3_arst_shut", K_SHUT, 0, 16'h0000);
    expectVal("s3_arst_done", K_DONE, 0, 16'h0);
    compareScoreboard();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Chain 4: no eligible boards.
    board_enable = 5'b00000;
    doReset();
    expectVal("s4_done", K_DONE, 0, 16'h1);
    expectVal("s4_cur", K_CUR, 0, 16'd5);
    compareScoreboard();
    readCheck("s4_read0", 9'h000, 16'hFFFF);
    readCheck("s4_read10", 9'h010, 16'hFFFF);
    applyStimulus(9'h048, 16'h1100, 1'b1, 1);
    expectVal("s4_conf", K_CONF, 0, 16'h0000);
    compareScoreboard();

    // Chain 5: Z2 base via 0x4A then 0x48.
    board_enable = 5'b11111;
    m68020 = 1'b0;
    doReset();
    applyStimulus(9'h04A, 16'h5000, 1'b1, 1);
    expectVal("s5_lo_noadv", K_CUR, 0, 16'd0);
    compareScoreboard();
    applyStimulus(9'h048, 16'hE000, 1'b1, 1);
`ifdef AUTOCONFIG_Z2_LOWNIB_EN
    expectVal("s5_base0", K_BASE, 0, 16'h00E5);
`else
    expectVal("s5_base0", K_BASE, 0, 16'h00E0);
`endif
    expectVal("s5_cur3", K_CUR, 0, 16'd3);
    compareScoreboard();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
